jtag_tap_ctrl: RTL and testbench
================================

# jtag_tap_ctrl

IEEE 1149.1 TAP controller that sequences the JTAG test-data-register block (`jtag_test_if`). It implements the 16-state TAP state machine and a 4-bit instruction register. It drives the DR-phase strobes and instruction selects into `jtag_test_if`, and owns the BYPASS and IDCODE registers. It also multiplexes the serial outputs of all data registers onto TDO and sits directly behind the JTAG pads.

## Interface
- `IR_LEN`, 4: instruction register width.
- `IDCODE_VALUE`, 32'h1180_0001: device ID; bit 0 must be 1.
- `OP_EXTEST`, 4'b0000: EXTEST opcode.
- `OP_SAMPLE`, 4'b0001: SAMPLE/PRELOAD opcode.
- `OP_IDCODE`, 4'b0010: IDCODE opcode.
- `OP_DEBUG`, 4'b1000: DEBUG opcode.
- `OP_MBIST`, 4'b1001: MBIST opcode.
- `OP_BYPASS`, 4'b1111: BYPASS opcode; every undefined opcode decodes as BYPASS.

Ports:
- `tck_i` in 1: test clock, the only clock.
- `trst_ni` in 1: asynchronous, active-low reset.
- `tms_i` in 1: mode select, sampled on rising `tck_i`.
- `tdi_i` in 1: serial input; sampled into IR/BYPASS/IDCODE on rising `tck_i`.
- `debug_tdi_i`, `bs_chain_tdi_i`, `mbist_tdi_i` in 1 each: serial outputs of the debug, boundary-scan and MBIST registers in `jtag_test_if`.
- `tdo_o` out 1: serial output.
- `tdo_oe_o` out 1: TDO pad enable.
- `test_logic_reset_o` out 1: active-high; high in Test-Logic-Reset or while `trst_ni`=0.
- `capture_dr_o`, `shift_dr_o`, `pause_dr_o`, `update_dr_o` out 1 each: high while in the matching DR state.
- `extest_select_o`, `sample_preload_select_o`, `mbist_select_o`, `debug_select_o` out 1 each: one-hot instruction decodes.
- `state_o` out 4: current TAP state encoding, for debug and bench observation.

## Operation
- **Reset:**
  - `trst_ni`=0 forces state Test-Logic-Reset (TLR) and IR = OP_IDCODE; BYPASS and IDCODE shift registers clear.
  - Outputs during reset: `tdo_o`=0, `tdo_oe_o`=0, `test_logic_reset_o`=1, all DR strobes 0, all selects 0.
- **State machine:** the standard 16 states, with transitions on rising `tck_i` per TMS:
  - TLR: 1→TLR, 0→RTI.
  - RTI: 1→SelDR, 0→RTI.
  - SelDR: 1→SelIR, 0→CapDR.
  - SelIR: 1→TLR, 0→CapIR.
  - CapXR: 1→Exit1XR, 0→ShiftXR.
  - ShiftXR: 1→Exit1XR, 0→ShiftXR.
  - Exit1XR: 1→UpdXR, 0→PauseXR.
  - PauseXR: 1→Exit2XR, 0→PauseXR.
  - Exit2XR: 1→UpdXR, 0→ShiftXR.
  - UpdXR: 1→SelDR, 0→RTI.
  - Five consecutive TMS=1 from any state reach TLR.
- **Entering TLR** by TMS (not only by `trst_ni`) reloads IR = OP_IDCODE.
- **DR strobes** are pure decodes of the state register; no glitches and no extra registration.
- **Instruction register:**
  - CapIR loads 4'b0101; LSBs 01 are mandatory.
  - ShiftIR shifts right, `tdi_i` into the MSB.
  - UpdIR copies the shift stage to the active IR on the rising edge leaving UpdIR.
  - The active IR changes only in UpdIR or TLR.
- **Selects:**
  - Decoded from the active IR, and asserted only when the state is not TLR.
  - At most one select is high; IDCODE and BYPASS assert none.
- **BYPASS:** 1-bit register; loads 0 in CapDR and shifts `tdi_i` in ShiftDR.
- **IDCODE:** 32-bit register; loads IDCODE_VALUE in CapDR and shifts right with `tdi_i` into the MSB in ShiftDR.
- **TDO source selection:**
  - ShiftIR: IR shift stage bit 0.
  - ShiftDR: the register selected by the active IR, one of `bs_chain_tdi_i` (EXTEST, SAMPLE), `debug_tdi_i`, `mbist_tdi_i`, IDCODE[0] or BYPASS.

## Timing
- TMS and TDI are sampled on rising `tck_i`.
- State, IR, BYPASS and IDCODE update on rising `tck_i`.
- `tdo_o` and `tdo_oe_o` are registered on falling `tck_i`:
  - `tdo_oe_o`=1 only in ShiftIR/ShiftDR.
  - `tdo_o` holds the selected source bit, and is 0 when `tdo_oe_o` is low.
- Capture occurs on the rising edge that leaves CapXR. Each following rising edge in ShiftXR shifts once, including the edge leaving ShiftXR on TMS=1.
- The first TDO bit is valid on the falling edge after entering ShiftXR.
- IR latency: a new instruction's select asserts on the rising edge leaving UpdIR, i.e. in the following RTI/SelDR state.
- Reset mid-shift: `trst_ni` low immediately forces TLR and IR=IDCODE and drops all strobes/selects. Shift contents are discarded, and no update is generated.
- PauseXR holds all shift registers; no capture or update occurs on resume through Exit2XR.

## Test plan
- **Async reset:** assert `trst_ni`=0 mid-ShiftDR → `state_o`=TLR immediately, `test_logic_reset_o`=1, `tdo_oe_o`=0, IR=4'b0010; release, TMS=0 → RTI.
- **TMS walk:** from RTI, drive TMS=1 for 5 cycles → TLR. Walk every arc of the 16-state graph, checking `state_o` and that each DR strobe is high only in its state.
- **IR scan:**
  - Shift 4'b1000 (DEBUG) → TDO returns 0101 (LSB first).
  - After UpdIR, `debug_select_o`=1 and the other selects are 0.
  - `debug_tdi_i` then appears on `tdo_o` in ShiftDR.
- **IDCODE:** after reset, CapDR then 32 shifts → TDO yields 32'h1180_0001 LSB first.
- **BYPASS:** load IR=4'b0110 (undefined) → BYPASS; shift 8'hA5 in → TDO shows 0 then A5 delayed one TCK; no select asserted.
- **Pause:** during EXTEST ShiftDR, go Pause→Exit2→Shift → `capture_dr_o` does not reassert, `pause_dr_o`=1 only in PauseDR, and the bit stream continues without loss.

Source files
------------

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller.
// It runs the 16-state TAP FSM and holds a 4-bit instruction register.
// It owns the BYPASS and IDCODE registers, drives the DR-phase strobes and
// the instruction selects into jtag_test_if, and multiplexes every data
// register onto TDO.
//
// Ports
//   tck_i, trst_ni          test clock, asynchronous active-low reset
//   tms_i, tdi_i            mode select and serial input, sampled on rising tck
//   debug_tdi_i             serial output of the debug register
//   bs_chain_tdi_i          serial output of the boundary-scan chain
//   mbist_tdi_i             serial output of the MBIST register
//   tdo_o, tdo_oe_o         serial output and pad enable, updated on falling tck
//   test_logic_reset_o      high in Test-Logic-Reset or during reset
//   capture/shift/pause/update_dr_o   DR state decodes
//   extest/sample_preload/mbist/debug_select_o   one-hot instruction decodes
//   state_o                 current TAP state encoding
module jtag_tap_ctrl #(
  parameter int unsigned        IR_LEN       = 4,
  parameter logic [31:0]        IDCODE_VALUE = 32'h1180_0001,
  parameter logic [IR_LEN-1:0]  OP_EXTEST    = IR_LEN'(4'b0000),
  parameter logic [IR_LEN-1:0]  OP_SAMPLE    = IR_LEN'(4'b0001),
  parameter logic [IR_LEN-1:0]  OP_IDCODE    = IR_LEN'(4'b0010),
  parameter logic [IR_LEN-1:0]  OP_DEBUG     = IR_LEN'(4'b1000),
  parameter logic [IR_LEN-1:0]  OP_MBIST     = IR_LEN'(4'b1001),
  parameter logic [IR_LEN-1:0]  OP_BYPASS    = IR_LEN'(4'b1111)
) (
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  input  logic       tdi_i,
  input  logic       debug_tdi_i,
  input  logic       bs_chain_tdi_i,
  input  logic       mbist_tdi_i,
  output logic       tdo_o,
  output logic       tdo_oe_o,
  output logic       test_logic_reset_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       pause_dr_o,
  output logic       update_dr_o,
  output logic       extest_select_o,
  output logic       sample_preload_select_o,
  output logic       mbist_select_o,
  output logic       debug_select_o,
  output logic [3:0] state_o
);

  localparam int unsigned ID_LEN = 32;
  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(4'b0101);

  // Conventional 1149.1 state encoding, visible on state_o
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  tap_state_e              state_q, state_d;
  logic [IR_LEN-1:0]       ir_shift_q;
  logic [IR_LEN-1:0]       ir_q;
  logic                    bypass_q;
  logic [ID_LEN-1:0]       idcode_q;
  logic                    tdo_src_c;
  logic                    is_extest, is_sample, is_idcode, is_debug, is_mbist, is_bypass;
  logic                    not_tlr;

  // TAP state register
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= TEST_LOGIC_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // TAP next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      TEST_LOGIC_RESET: state_d = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        state_d = tms_i ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = tms_i ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = tms_i ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = tms_i ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        state_d = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = tms_i ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = tms_i ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = tms_i ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  // Instruction register: shift stage plus active IR.
  // The active IR reloads IDCODE whenever TLR is occupied or about to be entered.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_shift_q <= IR_CAPTURE;
      ir_q       <= OP_IDCODE;
    end else begin
      case (state_q)
        CAPTURE_IR: ir_shift_q <= IR_CAPTURE;
        SHIFT_IR:   ir_shift_q <= {tdi_i, ir_shift_q[IR_LEN-1:1]};
        default:    ir_shift_q <= ir_shift_q;
      endcase
      if (state_q == TEST_LOGIC_RESET || state_d == TEST_LOGIC_RESET) begin
        ir_q <= OP_IDCODE;
      end else if (state_q == UPDATE_IR) begin
        ir_q <= ir_shift_q;
      end
    end
  end

  // BYPASS and IDCODE data registers
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      bypass_q <= 1'b0;
      idcode_q <= '0;
    end else begin
      case (state_q)
        CAPTURE_DR: begin
          bypass_q <= 1'b0;
          idcode_q <= IDCODE_VALUE;
        end
        SHIFT_DR: begin
          bypass_q <= tdi_i;
          idcode_q <= {tdi_i, idcode_q[ID_LEN-1:1]};
        end
        default: begin
          bypass_q <= bypass_q;
          idcode_q <= idcode_q;
        end
      endcase
    end
  end

  // Instruction decode; any opcode not listed behaves as BYPASS
  assign is_extest = (ir_q == OP_EXTEST);
  assign is_sample = (ir_q == OP_SAMPLE);
  assign is_idcode = (ir_q == OP_IDCODE);
  assign is_debug  = (ir_q == OP_DEBUG);
  assign is_mbist  = (ir_q == OP_MBIST);
  assign is_bypass = (ir_q == OP_BYPASS) |
                     ~(is_extest | is_sample | is_idcode | is_debug | is_mbist);

  assign not_tlr = (state_q != TEST_LOGIC_RESET);

  assign extest_select_o         = not_tlr & is_extest & ~is_bypass;
  assign sample_preload_select_o = not_tlr & is_sample & ~is_bypass;
  assign mbist_select_o          = not_tlr & is_mbist  & ~is_bypass;
  assign debug_select_o          = not_tlr & is_debug  & ~is_bypass;

  // DR strobes are straight decodes of the state register
  assign capture_dr_o       = (state_q == CAPTURE_DR);
  assign shift_dr_o         = (state_q == SHIFT_DR);
  assign pause_dr_o         = (state_q == PAUSE_DR);
  assign update_dr_o        = (state_q == UPDATE_DR);
  assign test_logic_reset_o = (state_q == TEST_LOGIC_RESET) | ~trst_ni;
  assign state_o            = state_q;

  // TDO source: IR shift stage in ShiftIR, selected data register in ShiftDR
  always_comb begin
    tdo_src_c = 1'b0;
    case (state_q)
      SHIFT_IR: tdo_src_c = ir_shift_q[0];
      SHIFT_DR: begin
        if (is_bypass) begin
          tdo_src_c = bypass_q;
        end else if (is_extest || is_sample) begin
          tdo_src_c = bs_chain_tdi_i;
        end else if (is_debug) begin
          tdo_src_c = debug_tdi_i;
        end else if (is_mbist) begin
          tdo_src_c = mbist_tdi_i;
        end else begin
          tdo_src_c = idcode_q[0];
        end
      end
      default: tdo_src_c = 1'b0;
    endcase
  end

  // TDO is launched on the falling edge so it is stable at the next rising edge
  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      tdo_oe_o <= (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
      tdo_o    <= tdo_src_c;
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: a driver applies TMS/TDI (directed
// scans plus a random walk) and pushes the expected outputs computed by a
// graph/queue reference model; a monitor pops and compares every cycle.
module tb_jtag_tap_ctrl;

  localparam logic [31:0] IDV = 32'h1180_0001;

  // Model state indices (independent of the DUT encoding)
  localparam int S_TLR = 0,  S_RTI = 1,  S_SDR = 2,   S_CDR = 3,   S_SHDR = 4,  S_E1DR = 5;
  localparam int S_PDR = 6,  S_E2DR = 7, S_UDR = 8,   S_SIR = 9,   S_CIR = 10,  S_SHIR = 11;
  localparam int S_E1IR = 12, S_PIR = 13, S_E2IR = 14, S_UIR = 15;

  int         nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int         nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  logic [3:0] code [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                            4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

  typedef struct packed {
    logic [3:0] st;
    logic       tlr;
    logic [3:0] strb;   // capture, shift, pause, update
    logic [3:0] sel;    // extest, sample, mbist, debug
    logic       oe;
    logic       tdo;
  } exp_t;

  logic tck, trst_n, tms, tdi, dbg_in, bs_in, mb_in;
  logic tdo, tdo_oe, tlr, cap_dr, sh_dr, pa_dr, up_dr;
  logic sel_ext, sel_samp, sel_mb, sel_dbg;
  logic [3:0] st;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int         m_st;
  logic [3:0] m_ir;
  bit         irq[$];
  bit         idq[$];
  bit         byq[$];

  jtag_tap_ctrl dut (
    .tck_i                   (tck),
    .trst_ni                 (trst_n),
    .tms_i                   (tms),
    .tdi_i                   (tdi),
    .debug_tdi_i             (dbg_in),
    .bs_chain_tdi_i          (bs_in),
    .mbist_tdi_i             (mb_in),
    .tdo_o                   (tdo),
    .tdo_oe_o                (tdo_oe),
    .test_logic_reset_o      (tlr),
    .capture_dr_o            (cap_dr),
    .shift_dr_o              (sh_dr),
    .pause_dr_o              (pa_dr),
    .update_dr_o             (up_dr),
    .extest_select_o         (sel_ext),
    .sample_preload_select_o (sel_samp),
    .mbist_select_o          (sel_mb),
    .debug_select_o          (sel_dbg),
    .state_o                 (st)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Reference model: one rising TCK edge, then the outputs seen after the next falling edge
  task automatic model_step(input bit rst, input bit t_ms, input bit t_di,
                            input bit bsv, input bit dbv, input bit mbv, output exp_t e);
    int s;
    logic [31:0] idv;
    idv = IDV;
    if (rst) begin
      m_st = S_TLR;
      m_ir = 4'b0010;
      irq  = {1'b0, 1'b0, 1'b0, 1'b0};
      idq.delete();
      for (int i = 0; i < 32; i++) idq.push_back(1'b0);
      byq = {1'b0};
    end else begin
      s = m_st;
      if (s == S_CIR) begin
        irq = {1'b1, 1'b0, 1'b1, 1'b0};          // 4'b0101, LSB first
      end else if (s == S_SHIR) begin
        void'(irq.pop_front());
        irq.push_back(t_di);
      end
      if (s == S_CDR) begin
        idq.delete();
        for (int i = 0; i < 32; i++) idq.push_back(idv[i]);
        byq = {1'b0};
      end else if (s == S_SHDR) begin
        void'(idq.pop_front());
        idq.push_back(t_di);
        void'(byq.pop_front());
        byq.push_back(t_di);
      end
      if (s == S_UIR) begin
        for (int i = 0; i < 4; i++) m_ir[i] = irq[i];
      end
      m_st = t_ms ? nxt1[s] : nxt0[s];
      if (m_st == S_TLR) m_ir = 4'b0010;
    end

    e      = '0;
    e.st   = code[m_st];
    e.tlr  = (m_st == S_TLR);
    e.strb = {m_st == S_CDR, m_st == S_SHDR, m_st == S_PDR, m_st == S_UDR};
    if (m_st != S_TLR)
      e.sel = {m_ir == 4'b0000, m_ir == 4'b0001, m_ir == 4'b1001, m_ir == 4'b1000};
    if (m_st == S_SHIR) begin
      e.oe  = 1'b1;
      e.tdo = irq[0];
    end else if (m_st == S_SHDR) begin
      e.oe = 1'b1;
      case (m_ir)
        4'b0000, 4'b0001: e.tdo = bsv;
        4'b1000:          e.tdo = dbv;
        4'b1001:          e.tdo = mbv;
        4'b0010:          e.tdo = idq[0];
        default:          e.tdo = byq[0];
      endcase
    end
  endtask

  // Driver: inputs change 2 ns after the falling edge, expectation queued
  task automatic step(input bit rst, input bit t_ms, input bit t_di);
    exp_t e;
    bit bsv, dbv, mbv;
    @(negedge tck);
    #2;
    bsv = 1'($urandom_range(0, 1));
    dbv = 1'($urandom_range(0, 1));
    mbv = 1'($urandom_range(0, 1));
    trst_n = !rst;
    tms    = t_ms;
    tdi    = t_di;
    bs_in  = bsv;
    dbg_in = dbv;
    mb_in  = mbv;
    model_step(rst, t_ms, t_di, bsv, dbv, mbv, e);
    exp_q.push_back(e);
  endtask

  // From RTI: load an instruction, back to RTI
  task automatic load_ir(input logic [3:0] op);
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, i == 3, op[i]);
    step(0, 1, 0); step(0, 0, 0);
  endtask

  // From RTI: capture, shift n bits, update, back to RTI
  task automatic scan_dr(input int n, input logic [63:0] data);
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < n; i++) step(0, i == n - 1, data[i]);
    step(0, 1, 0); step(0, 0, 0);
  endtask

  // From RTI: shift, detour through PauseDR, resume shifting, update
  task automatic scan_pause(input logic [7:0] d);
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 0, d[0]); step(0, 0, d[1]); step(0, 1, d[2]);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
    step(0, 0, d[3]); step(0, 0, d[4]); step(0, 0, d[5]); step(0, 0, d[6]); step(0, 1, d[7]);
    step(0, 1, 0); step(0, 0, 0);
  endtask

  // Monitor: compare every cycle that has a queued expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge tck);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state",   16'(st), 16'(e.st));
        chk("strobes", 16'({tlr, cap_dr, sh_dr, pa_dr, up_dr}), 16'({e.tlr, e.strb}));
        chk("selects", 16'({sel_ext, sel_samp, sel_mb, sel_dbg}), 16'(e.sel));
        chk("tdo",     16'({tdo_oe, tdo}), 16'({e.oe, e.tdo}));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    trst_n = 1'b0; tms = 1'b1; tdi = 1'b0;
    dbg_in = 1'b0; bs_in = 1'b0; mb_in = 1'b0;

    repeat (3) step(1, 1, 0);
    step(0, 0, 0);                                  // TLR -> RTI
    scan_dr(33, 64'h0);                             // IDCODE out after reset
    load_ir(4'b1000);                               // DEBUG
    scan_dr(8, 64'($urandom()));
    load_ir(4'b0110);                               // undefined -> BYPASS
    scan_dr(9, 64'h0A5);
    scan_pause(8'h3C);
    load_ir(4'b1001);                               // MBIST
    scan_dr(6, 64'($urandom()));
    load_ir(4'b0001);                               // SAMPLE
    scan_dr(5, 64'($urandom()));
    load_ir(4'b0010);                               // IDCODE, paused mid-stream
    scan_pause(8'hC5);
    load_ir(4'b0000);                               // EXTEST with pause
    scan_pause(8'h96);
    repeat (5) step(0, 1, 0);                       // five TMS=1 to TLR
    step(0, 0, 0);

    // Reset in the middle of an EXTEST DR shift
    load_ir(4'b0000);
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);
    step(1, 0, 0);
    #1;
    chk("async_state", 16'(st), 16'h000F);
    chk("async_outputs",
        16'({tlr, tdo_oe, tdo, cap_dr, sh_dr, pa_dr, up_dr, sel_ext, sel_samp, sel_mb, sel_dbg}),
        16'(11'b100_0000_0000));
    step(0, 0, 0);                                  // release, TLR -> RTI
    scan_dr(32, 64'h0);                             // IR reverted to IDCODE

    // Random walk with occasional resets and instruction loads
    for (int n = 0; n < 2500; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r < 6) begin
        repeat (5) step(0, 1, 0);
        step(0, 0, 0);
        load_ir(4'($urandom_range(0, 15)));
      end else begin
        step(0, int'($urandom_range(0, 99)) < 35, 1'($urandom_range(0, 1)));
      end
    end

    repeat (2) @(negedge tck);
    #3;
    chk("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
